data_memory_responder: RTL and testbench

//  Responder end of the memory-access-stage data path: accepts one load/store request at a time
//  via valid/ready, commits stores with SB/SH/SW byte-lane masking and returns load data after a

---
 rtl/data_memory_responder_pkg.sv | 37 +++
 rtl/data_memory_responder_dm_storage.sv | 38 +++
 rtl/data_memory_responder.sv | 123 ++++++++++++
 tb/tb_data_memory_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared types for the MEM-stage data memory responder: access type encodings,
// the responder FSM states and the store byte-lane mask helper.
package mem_pkg;

  typedef enum logic [1:0] {
    STORE_B = 2'd0,
    STORE_H = 2'd1,
    STORE_W = 2'd2
  } store_type_e;

  typedef enum logic [2:0] {
    LOAD_B,
    LOAD_H,
    LOAD_W,
    LOAD_BU,
    LOAD_HU
  } load_type_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } resp_state_e;

  localparam int unsigned CNT_W = 4;

  // Byte enables before alignment checks; misaligned halfwords are rejected upstream.
  function automatic logic [3:0] store_byte_en(input store_type_e st, input logic [1:0] off);
    case (st)
      STORE_B: return 4'b0001 << off;
      STORE_H: return 4'b0011 << off;
      STORE_W: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_dm_storage.sv
// Word-organised data storage: byte-enable synchronous write and a registered
// read port indexed by word. Contents are intentionally never reset.
module dm_storage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [3:0]      be,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic            re,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH_WORDS];
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] rdata_d;

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (be[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// MEM-stage data memory responder: one request at a time over valid/ready,
// stores commit on accept, load data returns right-aligned after READ_LATENCY cycles.
module data_memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned XLEN         = 32,
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_write,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [1:0]      req_store_type,
  output logic            resp_valid,
  input  logic            resp_ready,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_error
);

  localparam int unsigned      AW       = $clog2(DEPTH_WORDS);
  localparam logic [XLEN-1:0]  DEPTH_L  = XLEN'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(READ_LATENCY - 1);

  resp_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             write_q, write_d;
  logic             err_q, err_d;
  logic [1:0]       shift_q, shift_d;

  store_type_e      st;
  logic             hs, out_of_range, misaligned, req_err;
  logic [3:0]       be;
  logic [XLEN-1:0]  wdata_lane, rd_word;

  assign st           = store_type_e'(req_store_type);
  assign hs           = req_valid & req_ready;
  assign out_of_range = {2'b00, req_addr[XLEN-1:2]} >= DEPTH_L;
  assign misaligned   = req_write & ((st == STORE_H & req_addr[0]) |
                                     (st == STORE_W & (|req_addr[1:0])) |
                                     (req_store_type == 2'b11));
  assign req_err      = out_of_range | misaligned;
  assign be           = store_byte_en(st, req_addr[1:0]);
  assign wdata_lane   = req_wdata << {req_addr[1:0], 3'b000};

  dm_storage #(
    .XLEN        (XLEN),
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_storage (
    .clk   (clk),
    .we    (hs & req_write & ~req_err),
    .be    (be),
    .waddr (req_addr[AW+1:2]),
    .wdata (wdata_lane),
    .re    (hs & ~req_write),
    .raddr (req_addr[AW+1:2]),
    .rdata (rd_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    err_d   = err_q;
    shift_d = shift_q;
    case (state_q)
      IDLE: begin
        if (hs) begin
          write_d = req_write;
          err_d   = req_err;
          shift_d = req_addr[1:0];
          if (READ_LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          cnt_d   = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      err_q   <= err_d;
      shift_q <= shift_d;
    end
  end

  // Read word is held in the storage register, so the lane shift stays stable while RESP stalls.
  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == RESP);
    resp_error = resp_valid & err_q;
    resp_rdata = '0;
    if (resp_valid && !write_q && !err_q) resp_rdata = rd_word >> {shift_q, 3'b000};
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed scoreboard bench for data_memory_responder: a default-latency instance
// plus a single-cycle-latency instance sharing clock and reset.
module tb_data_memory_responder;

  localparam int unsigned RL = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0, resp_rdata;
  logic [1:0]  req_store_type = 2'd2;
  logic        resp_valid, resp_ready = 1'b1, resp_error;

  logic        req1_valid = 1'b0, req1_ready, req1_write = 1'b0;
  logic [31:0] req1_addr = '0, req1_wdata = '0, resp1_rdata;
  logic [1:0]  req1_store_type = 2'd2;
  logic        resp1_valid, resp1_ready = 1'b1, resp1_error;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       tag;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  data_memory_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .READ_LATENCY(RL)
  ) u_dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_store_type(req_store_type),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_error(resp_error)
  );

  data_memory_responder #(
    .XLEN(32), .DEPTH_WORDS(1024), .READ_LATENCY(1)
  ) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req1_valid), .req_ready(req1_ready), .req_write(req1_write),
    .req_addr(req1_addr), .req_wdata(req1_wdata), .req_store_type(req1_store_type),
    .resp_valid(resp1_valid), .resp_ready(resp1_ready),
    .resp_rdata(resp1_rdata), .resp_error(resp1_error)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One transaction on the main instance; hold>0 keeps resp_ready low that many cycles.
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] st, input logic [31:0] exp_rd, input logic exp_err,
                     input int hold, input string tag);
    exp_t e;
    int   cyc;
    int   lat;
    sb.push_back('{exp_rd, exp_err, tag});
    resp_ready = (hold == 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_store_type = st;
    cyc = 0;
    while (!req_ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, "_accept"}, {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, "_lat"}, 32'(lat), 32'(RL));
    e = sb.pop_front();
    chk({tag, "_rdata"}, resp_rdata, e.rdata);
    chk({tag, "_err"}, {31'd0, resp_error}, {31'd0, e.err});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_valid"}, {31'd0, resp_valid}, 32'd1);
      chk({tag, "_hold_rdata"}, resp_rdata, e.rdata);
      chk({tag, "_hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_done_valid"}, {31'd0, resp_valid}, 32'd0);
    chk({tag, "_done_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #12;
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_error", {31'd0, resp_error}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 32'h0, 1'b0, 0, "sw_10");
    txn(1'b0, 32'h11, 32'h0, 2'd0, 32'h00DEADBE, 1'b0, 0, "lb_11");
    txn(1'b1, 32'h20, 32'h11223344, 2'd2, 32'h0, 1'b0, 0, "sw_20");
    txn(1'b1, 32'h23, 32'h0000005A, 2'd0, 32'h0, 1'b0, 0, "sb_23");
    txn(1'b0, 32'h20, 32'h0, 2'd2, 32'h5A223344, 1'b0, 0, "lw_20");
    txn(1'b0, 32'h22, 32'h0, 2'd1, 32'h00005A22, 1'b0, 0, "lh_22");
    txn(1'b1, 32'h0, 32'hCAFEF00D, 2'd2, 32'h0, 1'b0, 0, "sw_00");
    txn(1'b1, 32'h1, 32'h0000BEEF, 2'd1, 32'h0, 1'b1, 0, "sh_01");
    txn(1'b1, 32'h4002, 32'h87654321, 2'd2, 32'h0, 1'b1, 0, "sw_4002");
    txn(1'b1, 32'h4000, 32'h87654321, 2'd2, 32'h0, 1'b1, 0, "sw_4000");
    txn(1'b0, 32'h0, 32'h0, 2'd2, 32'hCAFEF00D, 1'b0, 0, "lw_00");
    txn(1'b0, 32'h4000, 32'h0, 2'd2, 32'h0, 1'b1, 0, "lw_4000");
    txn(1'b1, 32'hFFC, 32'h01020304, 2'd2, 32'h0, 1'b0, 0, "sw_ffc");
    txn(1'b0, 32'hFFF, 32'h0, 2'd0, 32'h00000001, 1'b0, 0, "lb_fff");
    txn(1'b1, 32'h10, 32'h0, 2'd3, 32'h0, 1'b1, 0, "st3_10");
    txn(1'b1, 32'h12, 32'h00007777, 2'd1, 32'h0, 1'b0, 0, "sh_12");
    txn(1'b0, 32'h10, 32'h0, 2'd2, 32'h7777BEEF, 1'b0, 0, "lw_10");
    txn(1'b0, 32'h20, 32'h0, 2'd2, 32'h5A223344, 1'b0, 5, "lw_stall");

    // Reset while a load sits in WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h20; req_store_type = 2'd2;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    chk("midrst_wait_ready", {31'd0, req_ready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, resp_valid}, 32'd0);
    chk("midrst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("midrst_no_resp", {31'd0, resp_valid}, 32'd0);
    end
    txn(1'b0, 32'h23, 32'h0, 2'd0, 32'h0000005A, 1'b0, 0, "lb_after_rst");

    // Single-cycle latency instance; a load held valid across the store's RESP exit.
    @(negedge clk);
    req1_valid = 1'b1; req1_write = 1'b1; req1_addr = 32'h40;
    req1_wdata = 32'h12345678; req1_store_type = 2'd2;
    @(posedge clk);
    #1;
    chk("l1_sw_valid", {31'd0, resp1_valid}, 32'd1);
    chk("l1_sw_ready", {31'd0, req1_ready}, 32'd0);
    chk("l1_sw_err", {31'd0, resp1_error}, 32'd0);
    chk("l1_sw_rdata", resp1_rdata, 32'd0);
    req1_write = 1'b0; req1_addr = 32'h41;
    @(posedge clk);
    #1;
    chk("l1_exit_valid", {31'd0, resp1_valid}, 32'd0);
    chk("l1_exit_ready", {31'd0, req1_ready}, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    chk("l1_lb_valid", {31'd0, resp1_valid}, 32'd1);
    chk("l1_lb_rdata", resp1_rdata, 32'h00123456);
    @(posedge clk);
    #1;
    chk("l1_idle_ready", {31'd0, req1_ready}, 32'd1);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
